vec_alu_sequencer: RTL and testbench
====================================

// Module: vec_alu_sequencer
// PURPOSE
//  Time-multiplexes a full vector operation onto NUM_ALU element ALUs (alu_element_vec).
//  - Accepts a LANES-wide vector pair plus opcode over a valid/ready handshake.
//  - Issues NUM_ALU lanes per cycle and assembles the result vector.
//  - Presents the result on a valid/ready output. Sits between vector decode and vector writeback.
// PARAMETERS
//  ELEMENT  16  bits per lane (passed to alu_element_vec)
//  LANES     8  lanes per vector; LANES % NUM_ALU == 0 (elaboration error otherwise)
//  NUM_ALU   2  alu_element_vec instances; BEATS = LANES/NUM_ALU
// PORTS
//  clk        in   1                rising-edge clock
//  rst        in   1                synchronous reset, active-high
//  in_valid   in   1                request valid
//  in_ready   out  1                sequencer can accept a request
//  in_opcode  in   3                op; 3'b000 = add, all others yield zero lanes
//  in_vec_a   in   LANES*ELEMENT    operand A; lane i = bits [i*ELEMENT +: ELEMENT]
//  in_vec_b   in   LANES*ELEMENT    operand B, same packing
//  out_valid  out  1                result vector valid
//  out_ready  in   1                consumer accepts result
//  out_vec    out  LANES*ELEMENT    result vector, same packing
//  busy       out  1                high in EXEC or DONE
//  perf_ops   out  32               completed ops (only with VSEQ_PERF_EN)
// BEHAVIOUR
//  - Reset, synchronous, active-high. Takes effect on the first rising clk edge with rst=1:
//    state=IDLE, beat=0, out_valid=0, out_vec=0, busy=0, perf_ops=0.
//    in_ready is 0 while rst=1.
//  - FSM IDLE:
//    in_ready=1. On in_valid&in_ready, register opcode, A and B, clear beat, go to EXEC.
//  - FSM EXEC:
//    in_ready=0. Each cycle, ALU k computes lane beat*NUM_ALU+k.
//    Lane results are written into out_vec at the clock edge. beat increments.
//    When beat==BEATS-1, go to DONE.
//  - FSM DONE:
//    out_valid=1. out_vec is held stable until out_valid&out_ready, then go to IDLE.
//  - Latency: acceptance in cycle T gives out_valid high from cycle T+BEATS+1
//    (defaults: T+5). Minimum initiation interval is BEATS+2 cycles.
//  - Inputs are sampled only at acceptance. Changes on in_* during EXEC/DONE are ignored.
//  - Arithmetic: per-lane add modulo 2^ELEMENT; carry-out dropped, no cross-lane carry.
//  - Opcode != 000: full BEATS sequence still runs; all lanes are 0.
//  - out_vec lanes not yet written in EXEC keep their previous values.
//    Only the DONE-state value is architecturally defined.
//  - out_ready while out_valid=0 is ignored. in_valid during EXEC/DONE is held off (in_ready=0).
//  - Reset mid-EXEC or mid-DONE aborts the op. No out_valid is produced for it and perf_ops is unchanged.
// CONFIGURATION
//  - `VSEQ_PERF_EN defined:
//    perf_ops port exists. It increments on each out_valid&out_ready, wraps 2^32-1 -> 0, and resets to 0.
//  - `VSEQ_PERF_EN undefined:
//    perf_ops port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  - vseq_pkg:
//    typedef enum logic [2:0] {OP_ADD=3'b000} vseq_op_t;
//    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} vseq_state_t;
//    function beats(LANES, NUM_ALU).
//  - Sub-module: NUM_ALU instances of alu_element_vec (#(.element(ELEMENT))), via generate.
//    Operand lane select muxes and the FSM stay in this module.
//  - beat counter width: $clog2(BEATS) bits, minimum 1.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> out_valid=0, busy=0, out_vec=0, in_ready=0; after release in_ready=1.
//  2. Add: A lanes 1..8, B lanes 10..80, op=000 -> out_valid at T+5, lanes 11,22,..,88.
//  3. Wrap: A lanes 16'hFFFF, B lanes 16'h0002, op=000 -> all lanes 16'h0001, no spill into adjacent lanes.
//  4. Back-pressure: out_ready=0 for 10 cycles in DONE -> out_vec stable, in_ready=0.
//     Then out_ready=1 -> IDLE next cycle.
//  5. Non-add op=3'b101 and mid-EXEC input toggling -> latency still 5, all lanes 0; ignored inputs have no effect.
//  6. rst pulse at beat 2 -> IDLE, no out_valid.
//     Next op (A=B=lanes 3) -> lanes 6. With VSEQ_PERF_EN, perf_ops==1 after it.

Source files
------------

// File: rtl/vseq_pkg.sv
// rtl/vseq_pkg.sv - shared types and helpers for the vector ALU sequencer
package vseq_pkg;

    typedef enum logic [2:0] {OP_ADD = 3'b000} vseq_op_t;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} vseq_state_t;

    function automatic int beats(input int lanes, input int num_alu);
        return lanes / num_alu;
    endfunction

endpackage

// File: rtl/alu_element_vec.sv
// rtl/alu_element_vec.sv - single-lane element ALU: add modulo 2^element, zero for other opcodes
module alu_element_vec
    import vseq_pkg::*;
#(
    parameter int element = 16
) (
    input  logic [2:0]         opcode,
    input  logic [element-1:0] a,
    input  logic [element-1:0] b,
    output logic [element-1:0] result
);

    always_comb begin
        result = '0;
        if (opcode == OP_ADD) begin
            result = a + b;
        end
    end

endmodule

// File: rtl/vec_alu_sequencer.sv
// rtl/vec_alu_sequencer.sv - issues a LANES-wide vector op over NUM_ALU element ALUs in BEATS cycles
// Optional perf_ops completion counter enabled by VSEQ_PERF_EN.
module vec_alu_sequencer
    import vseq_pkg::*;
#(
    parameter int ELEMENT = 16,
    parameter int LANES   = 8,
    parameter int NUM_ALU = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_opcode,
    input  logic [LANES*ELEMENT-1:0]   in_vec_a,
    input  logic [LANES*ELEMENT-1:0]   in_vec_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*ELEMENT-1:0]   out_vec,
    output logic                       busy
`ifdef VSEQ_PERF_EN
    ,
    output logic [31:0]                perf_ops
`endif
);

    localparam int BEATS = beats(LANES, NUM_ALU);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VW    = LANES * ELEMENT;

    if (LANES % NUM_ALU != 0) begin : g_bad_cfg
        $error("vec_alu_sequencer: LANES must be a multiple of NUM_ALU");
    end

    vseq_state_t           state;
    vseq_state_t           state_next;
    logic [BW-1:0]         beat;
    logic [2:0]            op_q;
    logic [VW-1:0]         a_q;
    logic [VW-1:0]         b_q;
    logic [ELEMENT-1:0]    lane_a [NUM_ALU];
    logic [ELEMENT-1:0]    lane_b [NUM_ALU];
    logic [ELEMENT-1:0]    lane_r [NUM_ALU];
    logic                  accept;
    logic                  handshake;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
                if (beat == BW'(BEATS - 1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // Lane select: ALU k works on lane beat*NUM_ALU+k of the captured operands.
    always_comb begin
        for (int k = 0; k < NUM_ALU; k++) begin
            lane_a[k] = a_q[(int'(beat) * NUM_ALU + k) * ELEMENT +: ELEMENT];
            lane_b[k] = b_q[(int'(beat) * NUM_ALU + k) * ELEMENT +: ELEMENT];
        end
    end

    for (genvar k = 0; k < NUM_ALU; k++) begin : g_alu
        alu_element_vec #(.element(ELEMENT)) u_alu (
            .opcode (op_q),
            .a      (lane_a[k]),
            .b      (lane_b[k]),
            .result (lane_r[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            beat    <= '0;
            out_vec <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q <= in_opcode;
                a_q  <= in_vec_a;
                b_q  <= in_vec_b;
                beat <= '0;
            end
            if (state == S_EXEC) begin
                beat <= beat + 1'b1;
                for (int k = 0; k < NUM_ALU; k++) begin
                    out_vec[(int'(beat) * NUM_ALU + k) * ELEMENT +: ELEMENT] <= lane_r[k];
                end
            end
        end
    end

`ifdef VSEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops <= '0;
        end else if (handshake) begin
            perf_ops <= perf_ops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb/tb_vec_alu_sequencer.sv - directed bench with a transaction-level model for vec_alu_sequencer
module tb_vec_alu_sequencer;

    localparam int EL    = 16;
    localparam int LN    = 8;
    localparam int BEATS = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_opcode = 3'b000;
    logic [LN*EL-1:0] in_vec_a = '0;
    logic [LN*EL-1:0] in_vec_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [LN*EL-1:0] out_vec;
    logic            busy;
`ifdef VSEQ_PERF_EN
    logic [31:0]     perf_ops;
`endif

    int passed = 0;
    int total  = 0;

    vec_alu_sequencer #(.ELEMENT(EL), .LANES(LN), .NUM_ALU(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_vec_a  (in_vec_a),
        .in_vec_b  (in_vec_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .busy      (busy)
`ifdef VSEQ_PERF_EN
        ,
        .perf_ops  (perf_ops)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] mk(input int base, input int stride);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < LN; i++) v[i*EL +: EL] = 16'(base + stride * i);
        return v;
    endfunction

    // Transaction model: an accepted op is in flight, becomes visible BEATS+1 cycles later.
    logic         started = 1'b0;
    logic         inflight = 1'b0;
    int           age = 0;
    logic [127:0] exp_vec = '0;
    logic [31:0]  exp_perf = '0;

    always @(posedge clk) begin
        if (rst) begin
            started  = 1'b1;
            inflight = 1'b0;
            age      = 0;
            exp_perf = '0;
        end else if (!inflight) begin
            if (in_valid) begin
                inflight = 1'b1;
                age      = 0;
                for (int i = 0; i < LN; i++)
                    exp_vec[i*EL +: EL] = (in_opcode == 3'b000) ?
                        16'(in_vec_a[i*EL +: EL] + in_vec_b[i*EL +: EL]) : 16'h0;
            end
        end else if (age < BEATS) begin
            age++;
        end else if (out_ready) begin
            inflight = 1'b0;
            exp_perf++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_in_ready", 128'(in_ready), 128'(!rst && !inflight));
            chk("m_busy", 128'(busy), 128'(inflight));
            chk("m_out_valid", 128'(out_valid), 128'(inflight && age == BEATS));
            if (out_valid) chk("m_out_vec", out_vec, exp_vec);
`ifdef VSEQ_PERF_EN
            chk("m_perf_ops", 128'(perf_ops), 128'(exp_perf));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one op and returns the number of cycles from acceptance to out_valid.
    task automatic send(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b,
                        input bit toggle, output int lat);
        int n;
        in_opcode = op;
        in_vec_a  = a;
        in_vec_b  = b;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (toggle) begin
                in_valid  = 1'($urandom);
                in_opcode = 3'($urandom);
                in_vec_a  = {$urandom, $urandom, $urandom, $urandom};
                in_vec_b  = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int lat;
        logic [127:0] held;

        // Reset
        step();
        step();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_vec", out_vec, 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 128'(in_ready), 128'(1));

        // Plain add
        send(3'b000, mk(1, 1), mk(10, 10), 1'b0, lat);
        chk("add_latency", 128'(lat), 128'(5));
        chk("add_vec", out_vec, 128'h0058_004d_0042_0037_002c_0021_0016_000b);
        step();

        // Per-lane wrap
        send(3'b000, mk(16'hFFFF, 0), mk(2, 0), 1'b0, lat);
        chk("wrap_latency", 128'(lat), 128'(5));
        chk("wrap_vec", out_vec, 128'h0001_0001_0001_0001_0001_0001_0001_0001);
        step();

        // Back-pressure
        out_ready = 1'b0;
        send(3'b000, mk(100, 7), mk(5, 3), 1'b0, lat);
        chk("bp_latency", 128'(lat), 128'(5));
        held = mk(105, 10);
        for (int i = 0; i < 10; i++) begin
            chk("bp_vec_stable", out_vec, held);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            step();
        end
        chk("bp_still_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 128'(out_valid), 128'(0));
        chk("bp_release_ready", 128'(in_ready), 128'(1));

        // Non-add opcode with input churn during EXEC
        send(3'b101, mk(9, 9), mk(1, 2), 1'b1, lat);
        chk("nop_latency", 128'(lat), 128'(5));
        chk("nop_vec", out_vec, 128'(0));
        step();
        send(3'b000, mk(2, 0), mk(40, 1), 1'b0, lat);
        chk("after_nop_vec", out_vec, mk(42, 1));
        step();

        // Reset pulse at beat 2 aborts the op
        in_opcode = 3'b000;
        in_vec_a  = mk(50, 0);
        in_vec_b  = mk(50, 0);
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_valid", 128'(out_valid), 128'(0));
            step();
        end
        send(3'b000, mk(3, 0), mk(3, 0), 1'b0, lat);
        chk("post_abort_latency", 128'(lat), 128'(5));
        chk("post_abort_vec", out_vec, 128'h0006_0006_0006_0006_0006_0006_0006_0006);
        step();
`ifdef VSEQ_PERF_EN
        chk("perf_after_abort", 128'(perf_ops), 128'(1));
`endif
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
